// File: rtl/prog_loader.sv
// prog_loader: fills the core's instruction memory from an 8-bit valid/ready
// byte stream and holds the core in reset until the whole program is stored.
// Stream: LEN_HI, LEN_LO, then N x {HI, LO} where HI[0] is instruction bit 8.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the core is released.
module prog_loader #(
  parameter int D = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_reset,
  output logic         load_done,
  output logic         err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0, S_LEN_LO = 3'd1, S_INS_HI = 3'd2, S_INS_LO = 3'd3,
    S_CHK    = 3'd4, S_DONE   = 3'd5, S_ERR    = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0, S_LEN_LO = 3'd1, S_INS_HI = 3'd2, S_INS_LO = 3'd3,
    S_DONE   = 3'd5, S_ERR    = 3'd6
  } state_t;
`endif

  // Largest legal program: one word per memory location.
  localparam logic [16:0] MAX_N = 17'(2 ** D);

  state_t      state_q, state_d;
  logic [15:0] len_q;       // N, high byte captured first
  logic [D:0]  k_q;         // one extra bit so N = 2**D never wraps
  logic        hi_q;        // instruction bit 8 from the HI byte
  logic        accepting;
  logic        xfer;
  logic [15:0] n_in;
  logic        len_ok;
  logic        last_ins;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;      // XOR of every byte accepted so far
`endif

  // Byte acceptance: only in the collecting states, never while reset is held.
  always_comb begin
    accepting = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO: accepting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                                  accepting = 1'b1;
`endif
      default:                                accepting = 1'b0;
    endcase
  end

  assign in_ready = reset && accepting;
  assign xfer     = in_valid && in_ready;
  assign n_in     = {len_q[15:8], in_byte};
  assign len_ok   = (n_in != 16'd0) && ({1'b0, n_in} <= MAX_N);
  assign last_ins = (16'(k_q) == (len_q - 16'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_LEN_HI;
    else        state_q <= state_d;
  end

  // Next state: advance only on a transfer.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        S_LEN_HI: state_d = S_LEN_LO;
        S_LEN_LO: state_d = len_ok ? S_INS_HI : S_ERR;
        S_INS_HI: state_d = (in_byte[7:1] == 7'd0) ? S_INS_LO : S_ERR;
`ifdef LOADER_CHECKSUM_EN
        S_INS_LO: state_d = last_ins ? S_CHK : S_INS_HI;
        S_CHK:    state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
`else
        S_INS_LO: state_d = last_ins ? S_DONE : S_INS_HI;
`endif
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath: capture fields, issue the registered write, status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q      <= 16'd0;
      k_q        <= '0;
      hi_q       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      wr_en      <= 1'b0;
      load_done  <= (state_q == S_DONE);
      err        <= (state_q == S_ERR);
      core_reset <= (state_q != S_DONE);
      if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ in_byte;
`endif
        case (state_q)
          S_LEN_HI: len_q[15:8] <= in_byte;
          S_LEN_LO: len_q[7:0]  <= in_byte;
          S_INS_HI: hi_q        <= in_byte[0];
          S_INS_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= k_q[D-1:0];
            wr_data <= W'({hi_q, in_byte});
            k_q     <= k_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of header/HI-byte cases, directed sequences for
// timing, reset abort and max length, plus random streams checked against a
// stream-parsing reference model.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_byte = 8'h00;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       core_reset, load_done, err;

  prog_loader #(.D(10), .W(9)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int done_cyc = -1;
  logic [7:0]  sb[$];       // stream to send
  logic [18:0] wr_q[$];     // observed writes {addr, data}
  int          wrc_q[$];    // cycle of each observed write
  int          xfer_q[$];   // cycle of each accepted byte
  logic [18:0] exp_q[$];
  int exp_acc, exp_res;     // exp_res: 0 done, 1 err, 2 incomplete
  int acc_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back({wr_addr, wr_data});
      wrc_q.push_back(cyc);
    end
    if (load_done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    wr_q.delete(); wrc_q.delete(); xfer_q.delete(); done_cyc = -1;
  endtask

  task automatic sb_hdr(input int n);
    sb.delete();
    sb.push_back(8'(n >> 8));
    sb.push_back(8'(n));
  endtask

  task automatic sb_ins(input logic [7:0] hi, input logic [7:0] lo);
    sb.push_back(hi);
    sb.push_back(lo);
  endtask

  // Checksum byte when enabled; otherwise an optional stray byte after the
  // program, which the loader must ignore.
  task automatic sb_end(input bit bad);
    logic [7:0] c;
    c = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    foreach (sb[j]) c ^= sb[j];
    if (bad) c ^= 8'h01;
    sb.push_back(c);
`else
    if (bad) sb.push_back(8'hA5 ^ c);
`endif
  endtask

  // Reference: parse the stream by its format rules.
  task automatic model();
    int n, p;
    logic [7:0] hi, lo, c;
    exp_q.delete();
    n = {sb[0], sb[1]};
    p = 2;
    exp_acc = 2; exp_res = 1;
    if (n == 0 || n > 1024) return;
    for (int i = 0; i < n; i++) begin
      if (p + 1 >= sb.size() + 1) begin exp_acc = p; exp_res = 2; return; end
      hi = sb[p]; p++;
      if (hi[7:1] != 7'd0) begin exp_acc = p; exp_res = 1; return; end
      if (p >= sb.size()) begin exp_acc = p; exp_res = 2; return; end
      lo = sb[p]; p++;
      exp_q.push_back({10'(i), hi[0], lo});
    end
    exp_res = 0;
`ifdef LOADER_CHECKSUM_EN
    c = 8'h00;
    for (int j = 0; j < p; j++) c ^= sb[j];
    if (p >= sb.size()) exp_res = 2;
    else begin
      exp_res = (sb[p] == c) ? 0 : 1;
      p++;
    end
`endif
    exp_acc = p;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_byte = b; ok = 1'b0;
    #1;
    for (int t = 0; t < 4; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        xfer_q.push_back(cyc);
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int gap_max);
    bit ok;
    acc_cnt = 0;
    foreach (sb[i]) begin
      send_byte(sb[i], $urandom_range(0, gap_max), ok);
      if (!ok) break;
      acc_cnt++;
    end
    repeat (4) tick();
  endtask

  task automatic run_check(input string tag, input int gap_max);
    int m;
    do_reset();
    model();
    run_stream(gap_max);
    chk({tag, " accepted"}, acc_cnt, exp_acc);
    chk({tag, " nwrites"}, wr_q.size(), exp_q.size());
    m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, " write"}, wr_q[i], exp_q[i]);
    chk({tag, " err"}, err, exp_res == 1);
    chk({tag, " load_done"}, load_done, exp_res == 0);
    chk({tag, " core_reset"}, core_reset, exp_res != 0);
    chk({tag, " in_ready"}, in_ready, exp_res == 2);
  endtask

  typedef struct {
    logic [7:0] lh, ll, hi1;
    bit         exp_err;
    int         exp_wr;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n, nins;
    tbl[0] = '{8'h00, 8'h00, 8'h01, 1'b1, 0};
    tbl[1] = '{8'h04, 8'h01, 8'h01, 1'b1, 0};
    tbl[2] = '{8'hFF, 8'hFF, 8'h01, 1'b1, 0};
    tbl[3] = '{8'h00, 8'h02, 8'h02, 1'b1, 1};
    tbl[4] = '{8'h00, 8'h03, 8'h80, 1'b1, 1};
    tbl[5] = '{8'h00, 8'h02, 8'h01, 1'b0, 2};
    tbl[6] = '{8'h00, 8'h05, 8'h00, 1'b0, 5};
    tbl[7] = '{8'h00, 8'h01, 8'h00, 1'b0, 1};

    // Reset state, with a byte offered while reset is held.
    in_valid = 1'b1; in_byte = 8'h00;
    tick();
    chk("rst in_ready", in_ready, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst core_reset", core_reset, 1);
    chk("rst load_done", load_done, 0);
    chk("rst err", err, 0);
    in_valid = 1'b0;

    // Test 1: fixed program, back-to-back bytes, latency checks.
    sb_hdr(3); sb_ins(8'h01, 8'hA5); sb_ins(8'h00, 8'h00); sb_ins(8'h00, 8'hFF); sb_end(0);
    run_check("t1", 0);
    if (wr_q.size() == 3 && xfer_q.size() >= 8) begin
      chk("t1 w0", wr_q[0], {10'd0, 9'h1A5});
      chk("t1 w1", wr_q[1], {10'd1, 9'h000});
      chk("t1 w2", wr_q[2], {10'd2, 9'h0FF});
      chk("t1 wr latency", wrc_q[2] - xfer_q[7], 1);
      chk("t1 done latency", done_cyc - xfer_q[xfer_q.size() - 1], 2);
    end else chk("t1 shape", wr_q.size(), 3);

    // Test 2: same stream with idle gaps.
    for (int r = 0; r < 3; r++) run_check("t2 gaps", 5);

    // Header/HI-byte table.
    for (int v = 0; v < 8; v++) begin
      n = {tbl[v].lh, tbl[v].ll};
      sb_hdr(n);
      nins = (n >= 1 && n <= 1024) ? n : 1;
      for (int i = 0; i < nins; i++) sb_ins((i == 1) ? tbl[v].hi1 : 8'h01, 8'(i));
      sb_end(0);
      do_reset();
      run_stream(1);
      chk("tbl err", err, tbl[v].exp_err);
      chk("tbl load_done", load_done, !tbl[v].exp_err);
      chk("tbl core_reset", core_reset, tbl[v].exp_err);
      chk("tbl nwrites", wr_q.size(), tbl[v].exp_wr);
      chk("tbl in_ready", in_ready, 0);
    end

    // Test 5: reset while waiting for the LO byte of instruction 5 of 8.
    sb_hdr(8);
    for (int i = 0; i < 8; i++) sb_ins(8'($urandom_range(0, 1)), 8'($urandom));
    sb_end(0);
    do_reset();
    begin
      bit ok;
      for (int i = 0; i < 13; i++) send_byte(sb[i], 0, ok);
    end
    chk("t5 writes before", wr_q.size(), 5);
    reset = 1'b0; in_valid = 1'b1; in_byte = sb[13];
    #1;
    chk("t5 in_ready in reset", in_ready, 0);
    tick();
    chk("t5 wr_en", wr_en, 0);
    chk("t5 wr_addr", wr_addr, 0);
    chk("t5 wr_data", wr_data, 0);
    chk("t5 core_reset", core_reset, 1);
    chk("t5 load_done", load_done, 0);
    chk("t5 err", err, 0);
    reset = 1'b1; in_valid = 1'b0;
    run_check("t5 reload", 2);

    // Test 6: maximum length program.
    sb_hdr(1024);
    for (int i = 0; i < 1024; i++) sb_ins(8'($urandom_range(0, 1)), 8'($urandom));
    sb_end(0);
    run_check("t6 max", 0);
    if (wr_q.size() == 1024) chk("t6 last addr", wr_q[1023][18:9], 10'h3FF);

    // Bad checksum (or stray trailing byte in the default build).
    sb_hdr(3); sb_ins(8'h01, 8'h11); sb_ins(8'h00, 8'h22); sb_ins(8'h01, 8'h33); sb_end(1);
    run_check("bad tail", 1);

    // Random streams.
    for (int r = 0; r < 25; r++) begin
      int bad_i;
      n = $urandom_range(1, 20);
      bad_i = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      sb_hdr(n);
      for (int i = 0; i < n; i++)
        sb_ins((i == bad_i) ? (8'h02 << $urandom_range(0, 6)) | 8'($urandom_range(0, 1))
                            : 8'($urandom_range(0, 1)), 8'($urandom));
      sb_end($urandom_range(0, 3) == 0);
      run_check("rand", 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
